mesh_sort_pe: RTL and testbench

//  Second-generation mesh processing element for the sqrt(N) x sqrt(N) sorting mesh.

---
 rtl/mesh_pkg.sv | 43 ++++
 rtl/mesh_step_counter.sv | 31 +++
 rtl/mesh_sort_pe.sv | 246 ++++++++++++++++++++++++
 tb/tb_mesh_sort_pe.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mesh_pkg.sv
// Shared encodings and helpers for the sorting-mesh processing element:
// phase/stage/sequencer enums, record field offsets and per-phase lengths.
package mesh_pkg;

    typedef enum logic [2:0] {
        PH_SORT      = 3'd0,
        PH_ROW_ALIGN = 3'd1,
        PH_COL_ALIGN = 3'd2,
        PH_NOP       = 3'd7
    } phase_t;

    typedef enum logic [1:0] {
        ST_PUSH_ADDR = 2'd0,
        ST_GET_DATA  = 2'd1,
        ST_COMPUTE   = 2'd2
    } stage_t;

    typedef enum logic {
        FSM_IDLE = 1'b0,
        FSM_RUN  = 1'b1
    } fsm_t;

    // Record layout is {tag_row, tag_col, key}, key in the low bits.
    function automatic int tag_col_lsb(input int key_width);
        return key_width;
    endfunction

    function automatic int tag_row_lsb(input int key_width, input int tw);
        return key_width + tw;
    endfunction

    function automatic int phase_len(input phase_t ph, input int sqrt_n,
                                     input int passes, input int compute_cycles);
        int len;
        case (ph)
            PH_SORT:                   len = 2 * passes * sqrt_n;
            PH_ROW_ALIGN, PH_COL_ALIGN: len = sqrt_n;
            default:                   len = compute_cycles;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/mesh_step_counter.sv
// Free-running step/round counter with synchronous clear and increment enable.
module mesh_step_counter
    import mesh_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // Clear has priority over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + WIDTH'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/mesh_sort_pe.sv
// Sorting-mesh PE: round/phase sequencer plus odd-even compare-exchange datapath.
// Optional exchange counter output o_swaps when MESH_PE_SWAPCOUNT_EN is defined.
module mesh_sort_pe
    import mesh_pkg::*;
#(
    parameter int SQRT_N         = 8,
    parameter int ROW            = 0,
    parameter int COL            = 0,
    parameter int KEY_WIDTH      = 16,
    parameter int SORT_PASSES    = 4,
    parameter int COMPUTE_CYCLES = 3,
    parameter int ROUND_WIDTH    = 8,
    localparam int TW            = $clog2(SQRT_N),
    localparam int REC_W         = 2 * TW + KEY_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic [ROUND_WIDTH-1:0] i_rounds,
    input  logic                   i_load,
    input  logic [REC_W-1:0]       i_load_rec,
    input  logic [REC_W-1:0]       i_PE_l,
    input  logic [REC_W-1:0]       i_PE_r,
    input  logic [REC_W-1:0]       i_PE_u,
    input  logic [REC_W-1:0]       i_PE_d,
    output logic [REC_W-1:0]       o_PE,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [2:0]             o_phase,
    output logic [1:0]             o_stage
`ifdef MESH_PE_SWAPCOUNT_EN
    ,
    output logic [15:0]            o_swaps
`endif
);

    localparam int   TCW     = $clog2(2 * SORT_PASSES * SQRT_N + COMPUTE_CYCLES + 1);
    localparam int   COL_LSB = tag_col_lsb(KEY_WIDTH);
    localparam int   ROW_LSB = tag_row_lsb(KEY_WIDTH, TW);
    localparam int   FW      = (KEY_WIDTH > TW) ? KEY_WIDTH : TW;
    localparam logic ROW_ODD = 1'(ROW % 2);
    localparam logic COL_ODD = 1'(COL % 2);
    localparam logic HAS_L   = (COL > 0);
    localparam logic HAS_R   = (COL < SQRT_N - 1);
    localparam logic HAS_U   = (ROW > 0);
    localparam logic HAS_D   = (ROW < SQRT_N - 1);

    fsm_t                   r_state;
    phase_t                 r_phase;
    stage_t                 r_stage;
    logic                   r_busy;
    logic                   r_done;
    logic [REC_W-1:0]       r_rec;
    logic [ROUND_WIDTH-1:0] r_rounds_tgt;

    logic [TCW-1:0]         w_t;
    logic [ROUND_WIDTH-1:0] w_round;
    logic                   w_accept, w_last, w_final, w_t_clr, w_round_inc, w_done_next;
    logic                   w_row_step, w_has_partner, w_is_lower, w_ascend, w_take, w_exchange;
    logic [REC_W-1:0]       w_partner, w_next_rec;
    logic [FW-1:0]          w_own_f, w_par_f;

    function automatic logic [FW-1:0] field_of(input logic [REC_W-1:0] rec,
                                               input int lsb, input int width);
        logic [REC_W-1:0] v;
        v = (rec >> lsb) & ((REC_W'(1) << width) - REC_W'(1));
        return v[FW-1:0];
    endfunction

    mesh_step_counter #(.WIDTH(TCW)) u_step_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_t_clr),
        .i_inc   (1'b1),
        .o_count (w_t)
    );

    mesh_step_counter #(.WIDTH(ROUND_WIDTH)) u_round_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_accept),
        .i_inc   (w_round_inc),
        .o_count (w_round)
    );

    // Sequencer decode: phase end, final round, and the cycle before done.
    always_comb begin
        w_accept    = (r_state == FSM_IDLE) && i_start;
        w_last      = (w_t == TCW'(phase_len(r_phase, SQRT_N, SORT_PASSES, COMPUTE_CYCLES) - 1));
        w_final     = (w_round == (r_rounds_tgt - ROUND_WIDTH'(1)));
        w_t_clr     = (r_state == FSM_IDLE) || w_last;
        w_round_inc = (r_state == FSM_RUN) && (r_stage == ST_COMPUTE) && w_last && !w_final;
        w_done_next = (r_state == FSM_RUN) && w_final &&
                      (((r_stage == ST_COMPUTE) && !w_last &&
                        ((w_t + TCW'(1)) == TCW'(COMPUTE_CYCLES - 1))) ||
                       ((r_stage == ST_GET_DATA) && (r_phase == PH_COL_ALIGN) && w_last &&
                        (COMPUTE_CYCLES == 1)));
    end

    // Round/phase sequencer with registered handshake and phase/stage outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= FSM_IDLE;
            r_phase      <= PH_NOP;
            r_stage      <= ST_COMPUTE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_rounds_tgt <= '0;
        end else begin
            r_done <= w_done_next;
            case (r_state)
                FSM_IDLE: begin
                    if (i_start) begin
                        r_state      <= FSM_RUN;
                        r_phase      <= PH_SORT;
                        r_stage      <= ST_PUSH_ADDR;
                        r_busy       <= 1'b1;
                        r_rounds_tgt <= (i_rounds == ROUND_WIDTH'(0)) ? ROUND_WIDTH'(1) : i_rounds;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                FSM_RUN: begin
                    if (w_last) begin
                        case (r_stage)
                            ST_PUSH_ADDR, ST_GET_DATA: begin
                                case (r_phase)
                                    PH_SORT:      r_phase <= PH_ROW_ALIGN;
                                    PH_ROW_ALIGN: r_phase <= PH_COL_ALIGN;
                                    PH_COL_ALIGN: begin
                                        if (r_stage == ST_PUSH_ADDR) begin
                                            r_stage <= ST_GET_DATA;
                                            r_phase <= PH_SORT;
                                        end else begin
                                            r_stage <= ST_COMPUTE;
                                            r_phase <= PH_NOP;
                                        end
                                    end
                                    default:      r_phase <= PH_NOP;
                                endcase
                            end
                            default: begin
                                if (w_final) begin
                                    r_state <= FSM_IDLE;
                                    r_busy  <= 1'b0;
                                end else begin
                                    r_stage <= ST_PUSH_ADDR;
                                    r_phase <= PH_SORT;
                                end
                            end
                        endcase
                    end else begin
                        r_busy <= 1'b1;
                    end
                end
                default: r_state <= FSM_IDLE;
            endcase
        end
    end

    // Partner selection and compare: row steps use COL parity, column steps ROW parity.
    always_comb begin
        w_row_step = (r_phase == PH_COL_ALIGN) || ((r_phase == PH_SORT) && !w_t[TW]);
        if (w_row_step) begin
            w_ascend = !((r_phase == PH_SORT) && ROW_ODD);
            if (COL_ODD == w_t[0]) begin
                w_is_lower    = 1'b1;
                w_has_partner = HAS_R;
                w_partner     = i_PE_r;
            end else begin
                w_is_lower    = 1'b0;
                w_has_partner = HAS_L;
                w_partner     = i_PE_l;
            end
        end else begin
            w_ascend = 1'b1;
            if (ROW_ODD == w_t[0]) begin
                w_is_lower    = 1'b1;
                w_has_partner = HAS_D;
                w_partner     = i_PE_d;
            end else begin
                w_is_lower    = 1'b0;
                w_has_partner = HAS_U;
                w_partner     = i_PE_u;
            end
        end
        case (r_phase)
            PH_ROW_ALIGN: begin
                w_own_f = field_of(r_rec, ROW_LSB, TW);
                w_par_f = field_of(w_partner, ROW_LSB, TW);
            end
            PH_COL_ALIGN: begin
                w_own_f = field_of(r_rec, COL_LSB, TW);
                w_par_f = field_of(w_partner, COL_LSB, TW);
            end
            default: begin
                w_own_f = field_of(r_rec, 0, KEY_WIDTH);
                w_par_f = field_of(w_partner, 0, KEY_WIDTH);
            end
        endcase
        // Lower position keeps the min when ascending; strict compare leaves ties in place.
        w_take     = w_has_partner &&
                     ((w_is_lower == w_ascend) ? (w_par_f < w_own_f) : (w_par_f > w_own_f));
        w_exchange = (r_state == FSM_RUN) && (r_stage != ST_COMPUTE) && w_take;
        w_next_rec = w_exchange ? w_partner : r_rec;
    end

    // Record register: loads only in IDLE, otherwise follows the exchange result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rec <= '0;
        end else if ((r_state == FSM_IDLE) && i_load) begin
            r_rec <= i_load_rec;
        end else begin
            r_rec <= w_next_rec;
        end
    end

`ifdef MESH_PE_SWAPCOUNT_EN
    logic [15:0] r_swaps;

    // Saturating count of cycles where an exchange altered the record.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_swaps <= 16'h0000;
        end else if (w_accept) begin
            r_swaps <= 16'h0000;
        end else if (w_exchange && (w_partner != r_rec) && (r_swaps != 16'hFFFF)) begin
            r_swaps <= r_swaps + 16'h0001;
        end else begin
            r_swaps <= r_swaps;
        end
    end

    assign o_swaps = r_swaps;
`else
    // Default build carries no exchange counter.
`endif

    assign o_PE    = r_rec;
    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_phase = r_phase;
    assign o_stage = r_stage;

endmodule

// File: tb/tb_mesh_sort_pe.sv
// 4x4 mesh bench: randomized loads checked cycle-by-cycle against a whole-mesh
// odd-even transposition reference model plus closed-form expectations.
module tb_mesh_sort_pe;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_start, i_load;
    logic [7:0]   i_rounds;
    logic [191:0] load_v;
    wire  [191:0] pe_v;
    wire  [15:0]  busy_v, done_v;
    wire  [47:0]  ph_v;
    wire  [31:0]  st_v;
`ifdef MESH_PE_SWAPCOUNT_EN
    wire  [255:0] sw_v;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [11:0] m [16];

    always #5 clk = ~clk;

    for (genvar r = 0; r < 4; r++) begin : g_r
        for (genvar c = 0; c < 4; c++) begin : g_c
            mesh_sort_pe #(.SQRT_N(4), .ROW(r), .COL(c), .KEY_WIDTH(8), .SORT_PASSES(3),
                           .COMPUTE_CYCLES(3), .ROUND_WIDTH(8)) u_pe (
                .clk        (clk),
                .rst        (rst),
                .i_start    (i_start),
                .i_rounds   (i_rounds),
                .i_load     (i_load),
                .i_load_rec (load_v[(r*4+c)*12 +: 12]),
                .i_PE_l     (pe_v[(r*4+(c+3)%4)*12 +: 12]),
                .i_PE_r     (pe_v[(r*4+(c+1)%4)*12 +: 12]),
                .i_PE_u     (pe_v[(((r+3)%4)*4+c)*12 +: 12]),
                .i_PE_d     (pe_v[(((r+1)%4)*4+c)*12 +: 12]),
                .o_PE       (pe_v[(r*4+c)*12 +: 12]),
                .o_busy     (busy_v[r*4+c]),
                .o_done     (done_v[r*4+c]),
                .o_phase    (ph_v[(r*4+c)*3 +: 3]),
                .o_stage    (st_v[(r*4+c)*2 +: 2])
`ifdef MESH_PE_SWAPCOUNT_EN
                ,
                .o_swaps    (sw_v[(r*4+c)*16 +: 16])
`endif
            );
        end
    end

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic int fld(input logic [11:0] rec, input int sel);
        case (sel)
            0:       return int'(rec[7:0]);
            1:       return int'(rec[11:10]);
            default: return int'(rec[9:8]);
        endcase
    endfunction

    function automatic logic [191:0] pack_model();
        logic [191:0] v;
        for (int k = 0; k < 16; k++) v[k*12 +: 12] = m[k];
        return v;
    endfunction

    function automatic logic [255:0] ctl_obs();
        return {144'd0, busy_v, done_v, ph_v, st_v};
    endfunction

    function automatic logic [255:0] ctl_exp(input logic b, input logic d, input int ph, input int st);
        logic [2:0] p;
        logic [1:0] s;
        p = 3'(ph);
        s = 2'(st);
        return {144'd0, {16{b}}, {16{d}}, {16{p}}, {16{s}}};
    endfunction

    // Row pass over pairs (c,c+1) starting at column par; snake rows descend when odd.
    task automatic row_step(input int par, input int sel, input bit snake);
        logic [11:0] a, b;
        bit asc;
        for (int r = 0; r < 4; r++) begin
            asc = !(snake && (r % 2 == 1));
            for (int c = par; c < 3; c += 2) begin
                a = m[r*4+c];
                b = m[r*4+c+1];
                if (asc ? (fld(a, sel) > fld(b, sel)) : (fld(a, sel) < fld(b, sel))) begin
                    m[r*4+c]   = b;
                    m[r*4+c+1] = a;
                end
            end
        end
    endtask

    task automatic col_step(input int par, input int sel);
        logic [11:0] a, b;
        for (int c = 0; c < 4; c++) begin
            for (int r = par; r < 3; r += 2) begin
                a = m[r*4+c];
                b = m[(r+1)*4+c];
                if (fld(a, sel) > fld(b, sel)) begin
                    m[r*4+c]     = b;
                    m[(r+1)*4+c] = a;
                end
            end
        end
    endtask

    task automatic model_step(input int st, input int ph, input int t);
        if (st != 2) begin
            case (ph)
                0: if (t % 8 < 4) row_step(t % 2, 0, 1'b1); else col_step(t % 2, 0);
                1: col_step(t % 2, 1);
                2: row_step(t % 2, 2, 1'b0);
                default: ;
            endcase
        end
    endtask

    // Load + start one run, then compare DUT against the model every cycle.
    task automatic run_case(input string name, input logic [191:0] init, input logic [7:0] rounds,
                            input int poke_at, input int abort_at, input int snake_at,
                            input logic [191:0] snake_exp);
        int eff, total, ndone, first_done;
        int sch_st[$], sch_ph[$], sch_t[$];
        eff = (rounds == 8'd0) ? 1 : int'(rounds);
        for (int rd = 0; rd < eff; rd++) begin
            for (int st = 0; st < 2; st++)
                for (int ph = 0; ph < 3; ph++)
                    for (int t = 0; t < ((ph == 0) ? 24 : 4); t++) begin
                        sch_st.push_back(st); sch_ph.push_back(ph); sch_t.push_back(t);
                    end
            for (int t = 0; t < 3; t++) begin
                sch_st.push_back(2); sch_ph.push_back(7); sch_t.push_back(t);
            end
        end
        total = sch_st.size();
        load_v = init; i_load = 1'b1; i_start = 1'b1; i_rounds = rounds;
        @(negedge clk);
        i_load = 1'b0; i_start = 1'b0; i_rounds = 8'($urandom);
        for (int k = 0; k < 16; k++) m[k] = init[k*12 +: 12];
        ndone = 0; first_done = -1;
        for (int j = 0; j < total; j++) begin
            if (j == abort_at) begin
                rst = 1'b1;
                #1;
                check_eq({name, "_rst_ctl"}, ctl_obs(), ctl_exp(1'b0, 1'b0, 7, 2));
                check_eq({name, "_rst_rec"}, {64'd0, pe_v}, 256'd0);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            check_eq({name, "_ctl"}, ctl_obs(),
                     ctl_exp(1'b1, (j == total - 1), sch_ph[j], sch_st[j]));
            check_eq({name, "_mesh"}, {64'd0, pe_v}, {64'd0, pack_model()});
            if (j == snake_at) check_eq({name, "_snake"}, {64'd0, pe_v}, {64'd0, snake_exp});
            if (done_v[0]) begin
                ndone++;
                if (first_done < 0) first_done = j + 1;
            end
            model_step(sch_st[j], sch_ph[j], sch_t[j]);
            i_start = (j == poke_at);
            i_load  = (j == poke_at);
            if (j == poke_at) for (int k = 0; k < 6; k++) load_v[k*32 +: 32] = $urandom;
            @(negedge clk);
        end
        i_start = 1'b0; i_load = 1'b0;
        check_eq({name, "_idle_ctl"}, ctl_obs(), ctl_exp(1'b0, 1'b0, 7, 2));
        check_eq({name, "_final"}, {64'd0, pe_v}, {64'd0, pack_model()});
        check_eq({name, "_done_cnt"}, 256'(ndone), 256'd1);
        check_eq({name, "_done_lat"}, 256'(first_done), 256'(67 * eff));
    endtask

    initial begin
        logic [191:0] init, exp_v;
        logic seen_done;
        int k, orig;
        rst = 1'b1; i_start = 1'b0; i_load = 1'b0; i_rounds = 8'd0; load_v = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen_done = seen_done | (|done_v);
        end
        check_eq("reset_rec", {64'd0, pe_v}, 256'd0);
        check_eq("reset_ctl", ctl_obs(), ctl_exp(1'b0, 1'b0, 7, 2));
        check_eq("reset_no_done", 256'(seen_done), 256'd0);

        // Reverse keys, identity tags: first SORT phase yields snake order 0..15.
        for (int i = 0; i < 16; i++) init[i*12 +: 12] = {2'(i / 4), 2'(i % 4), 8'(15 - i)};
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                k = r * 4 + ((r % 2 == 0) ? c : 3 - c);
                orig = 15 - k;
                exp_v[(r*4+c)*12 +: 12] = {2'(orig / 4), 2'(orig % 4), 8'(k)};
            end
        run_case("snake", init, 8'd1, -1, -1, 24, exp_v);

        // Equal keys, tags form a column-then-row routable permutation.
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                init[(r*4+c)*12 +: 12]  = {2'((r + c) % 4), 2'((r + 2 * c) % 4), 8'h33};
                exp_v[(r*4+c)*12 +: 12] = {2'(r), 2'(c), 8'h33};
            end
        run_case("route", init, 8'd1, 30, -1, -1, '0);
        check_eq("route_dest", {64'd0, pe_v}, {64'd0, exp_v});

        // All keys equal with aligned tags: nothing may move.
        for (int i = 0; i < 16; i++) init[i*12 +: 12] = {2'(i / 4), 2'(i % 4), 8'h55};
        run_case("equal", init, 8'd1, -1, -1, -1, '0);
        check_eq("equal_hold", {64'd0, pe_v}, {64'd0, init});
`ifdef MESH_PE_SWAPCOUNT_EN
        check_eq("equal_swaps", sw_v, 256'd0);
`endif

        // Abort mid ROW_ALIGN, then randomized runs with busy-time start/load pokes.
        for (int i = 0; i < 6; i++) init[i*32 +: 32] = $urandom;
        run_case("abort", init, 8'd1, -1, 25, -1, '0);
        for (int i = 0; i < 6; i++) init[i*32 +: 32] = $urandom;
        run_case("rand_r2", init, 8'd2, 100, -1, -1, '0);
        for (int i = 0; i < 6; i++) init[i*32 +: 32] = $urandom;
        run_case("rand_r0", init, 8'd0, 10, -1, -1, '0);
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 6; i++) init[i*32 +: 32] = $urandom;
            run_case("rand", init, 8'($urandom_range(1, 3)), int'($urandom_range(1, 60)), -1, -1, '0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
